// File: rtl/demux_route_ctrl.sv
// Single-entry routing controller for the 1-to-4 demux, with per-channel transfer counters.
// Optional stall-timeout drop is compiled in with DEMUX_TIMEOUT_EN.
module demux_route_ctrl #(
    parameter int DW      = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    in_data,
    input  logic [1:0]       in_dest,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DW-1:0]    out_data,
    output logic [1:0]       sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic             busy,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_out,
    output logic             drop
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DW-1:0]     data_q;
    logic [1:0]        sel_q;
    logic              hold;
    logic              xfer;
    logic              acc;
    logic              expire;
    logic [CNT_W-1:0]  cnt [4];

    assign hold     = (state == HOLD);
    assign xfer     = hold & out_ready[sel_q];
    // Ready passes straight through from the consumer so a word can reload every cycle.
    assign in_ready = ~hold | xfer;
    assign acc      = in_valid & in_ready;

    assign out_data  = data_q;
    assign sel       = sel_q;
    assign busy      = hold;
    assign out_valid = hold ? (4'b0001 << sel_q) : 4'b0000;
    assign cnt_out   = cnt[cnt_sel];

`ifdef DEMUX_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT - 1);

    logic [7:0] timer;
    logic       drop_q;

    // A transfer in the last stalled cycle takes priority over the drop.
    assign expire = hold & ~xfer & (timer == TO_LIM);
    assign drop   = drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            timer  <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= expire;
            if (acc) begin
                timer <= '0;
            end else if (hold && !xfer) begin
                timer <= timer + 8'd1;
            end
        end
    end
`else
    assign expire = 1'b0;
    assign drop   = 1'b0 & (TIMEOUT > 0);
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (acc) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (acc) begin
                    state_nx = HOLD;
                end else if (xfer || expire) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            data_q <= '0;
            sel_q  <= 2'd0;
        end else begin
            state <= state_nx;
            if (acc) begin
                data_q <= in_data;
                sel_q  <= in_dest;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                cnt[i] <= '0;
            end else if (xfer && (sel_q == 2'(i))) begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Directed bench for demux_route_ctrl: transaction-level model checked every cycle,
// plus hand-computed literal expectations per scenario.
module tb_demux_route_ctrl;

    localparam int DW    = 8;
    localparam int CW    = 4;
    localparam int TO    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic [1:0]    in_dest;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    sel;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic          busy;
    logic [1:0]    cnt_sel;
    logic [CW-1:0] cnt_out;
    logic          drop;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    demux_route_ctrl #(.DW(DW), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .cnt_sel   (cnt_sel),
        .cnt_out   (cnt_out),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one optional held entry, its age in stalled cycles, four counts.
    bit          m_full;
    logic [7:0]  m_data;
    logic [1:0]  m_dest;
    int          m_age;
    int          m_cnt [4];
    bit          m_drop;
    bit          m_xf;
    bit          m_ac;
    bit          m_ex;

    always @(posedge clk) begin
        if (rst) begin
            m_full = 0;
            m_data = '0;
            m_dest = '0;
            m_age  = 0;
            m_drop = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            m_xf = m_full && out_ready[m_dest];
            m_ac = in_valid && (!m_full || m_xf);
            m_ex = 0;
`ifdef DEMUX_TIMEOUT_EN
            if (m_full && !m_xf) begin
                m_age++;
                if (m_age >= TO) m_ex = 1;
            end
`endif
            m_drop = m_ex;
            if (m_xf) m_cnt[m_dest] = (m_cnt[m_dest] + 1) % (1 << CW);
            if (m_ac) begin
                m_full = 1;
                m_data = in_data;
                m_dest = in_dest;
                m_age  = 0;
            end else if (m_xf || m_ex) begin
                m_full = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 32'(out_valid),
                  m_full ? 32'(4'b0001 << m_dest) : 32'd0);
            check("in_ready", 32'(in_ready),
                  32'(!m_full || out_ready[m_dest]));
            check("busy", 32'(busy), 32'(m_full));
            check("drop", 32'(drop), 32'(m_drop));
            check("sel", 32'(sel), 32'(m_dest));
            check("out_data", 32'(out_data), 32'(m_data));
            check("cnt_out", 32'(cnt_out), 32'(m_cnt[cnt_sel]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic cnt_is(input logic [1:0] ch, input int exp, input string nm);
        cnt_sel = ch;
        #1;
        check(nm, 32'(cnt_out), 32'(exp));
    endtask

    initial begin
        logic [7:0] b2b_d [4];
        logic [1:0] b2b_s [4];
        logic [3:0] b2b_v [4];
        b2b_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        b2b_s = '{2'd0, 2'd3, 2'd2, 2'd1};
        b2b_v = '{4'b0001, 4'b1000, 4'b0100, 4'b0010};

        // Reset with a pending word and all consumers ready.
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_dest   = 2'd2;
        in_data   = 8'h77;
        out_ready = 4'hF;
        cnt_sel   = 2'd0;
        tick();
        tick();
        chk_en = 1'b1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst sel", 32'(sel), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) cnt_is(2'(i), 0, "rst cnt");
        rst = 1'b0;
        tick();
        in_valid = 1'b0;
        check("first out_valid", 32'(out_valid), 32'h4);
        check("first data", 32'(out_data), 32'h77);
        tick();

        // Single route.
        do_reset();
        out_ready = 4'b0010;
        in_data   = 8'hA5;
        in_dest   = 2'd1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("single sel", 32'(sel), 32'd1);
        check("single out_valid", 32'(out_valid), 32'h2);
        check("single data", 32'(out_data), 32'hA5);
        cnt_is(2'd1, 0, "single pre cnt");
        tick();
        check("single idle", 32'(busy), 32'd0);
        cnt_is(2'd1, 1, "single cnt1");

        // Back-to-back across all four destinations.
        do_reset();
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            in_data  = b2b_d[i];
            in_dest  = b2b_s[i];
            in_valid = 1'b1;
            tick();
            check("b2b out_valid", 32'(out_valid), 32'(b2b_v[i]));
            check("b2b in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) cnt_is(2'(i), 1, "b2b cnt");

        // Stall on channel 3; a new upstream word must be ignored meanwhile.
        do_reset();
        out_ready = 4'b0111;
        in_data   = 8'hC3;
        in_dest   = 2'd3;
        in_valid  = 1'b1;
        tick();
        in_data = 8'h5E;
        in_dest = 2'd0;
        for (int i = 0; i < 5; i++) begin
            check("stall out_valid", 32'(out_valid), 32'h8);
            check("stall in_ready", 32'(in_ready), 32'd0);
            check("stall data", 32'(out_data), 32'hC3);
            cnt_is(2'd3, 0, "stall cnt3");
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 4'hF;
        #1;
        check("stall release in_ready", 32'(in_ready), 32'd1);
        tick();
        cnt_is(2'd3, 1, "stall cnt3 after");
        check("stall idle", 32'(busy), 32'd0);

        // Counter wrap: 17 transfers to channel 0 on a 4-bit counter.
        do_reset();
        out_ready = 4'hF;
        in_dest   = 2'd0;
        in_valid  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        cnt_is(2'd0, 1, "wrap cnt0");

`ifdef DEMUX_TIMEOUT_EN
        // Destination never ready: held 4 cycles, then a one-cycle drop.
        do_reset();
        out_ready = 4'b1011;
        in_data   = 8'h9D;
        in_dest   = 2'd2;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            check("to out_valid", 32'(out_valid), 32'h4);
            check("to drop low", 32'(drop), 32'd0);
            tick();
        end
        check("to drop", 32'(drop), 32'd1);
        check("to idle", 32'(busy), 32'd0);
        check("to out_valid off", 32'(out_valid), 32'd0);
        cnt_is(2'd2, 0, "to cnt2");
        tick();
        check("to drop pulse", 32'(drop), 32'd0);

        // Ready arrives in the last allowed cycle: transfer wins.
        do_reset();
        out_ready = 4'b1011;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < TO - 1; i++) tick();
        out_ready = 4'hF;
        #1;
        check("to last in_ready", 32'(in_ready), 32'd1);
        tick();
        check("to last drop", 32'(drop), 32'd0);
        cnt_is(2'd2, 1, "to last cnt2");
        tick();
        check("to last drop2", 32'(drop), 32'd0);
`else
        // Without the timeout a stalled entry waits indefinitely.
        do_reset();
        out_ready = 4'b1011;
        in_dest   = 2'd2;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("hold busy", 32'(busy), 32'd1);
        check("hold drop", 32'(drop), 32'd0);
        out_ready = 4'hF;
        tick();
        cnt_is(2'd2, 1, "hold cnt2");
`endif

        // Reset while holding discards the entry without counting.
        out_ready = 4'b0000;
        in_dest   = 2'd1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        do_reset();
        check("midrst busy", 32'(busy), 32'd0);
        cnt_is(2'd1, 0, "midrst cnt1");
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
